// File: rtl/dct_forward_transform.sv
// Forward 8x8 DCT-II for the JPEG encoder datapath.
// A row DCT writes each incoming pixel row into one of two transpose banks.
// A column DCT reads a complete bank to produce one coefficient row per cycle.
// The framing flags travel through a 10-stage shift register. Each stage also
// carries the row index and bank, which time the bank write and the column read.
module dct_forward_transform (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [7:0][7:0]         in_data,
    input  logic                    in_sob,
    input  logic                    in_eob,
    input  logic                    in_sof,
    output logic                    out_valid,
    output logic signed [7:0][15:0] out_data,
    output logic                    out_sob,
    output logic                    out_eob,
    output logic                    out_sof
);

    localparam int Depth = 10;

    typedef struct packed {
        logic       valid;
        logic       sob;
        logic       eob;
        logic       sof;
        logic [2:0] row;
        logic       bank;
    } ctrl_t;

    // Returns 0.5*C(k)*cos((2n+1)k*pi/16), scaled by 2^16.
    // The C(0) = 1/sqrt2 case equals 0.5*cos(pi/4).
    function automatic logic signed [17:0] dctCoef(input int k, input int n);
        int               a;
        logic signed [17:0] mag;
        logic             neg;
        a   = ((2 * n + 1) * k) % 32;
        neg = 1'b0;
        if (a > 16) a = 32 - a;
        if (a > 8) begin
            a   = 16 - a;
            neg = 1'b1;
        end
        case (a)
            0:       mag = 18'sd32768;
            1:       mag = 18'sd32138;
            2:       mag = 18'sd30274;
            3:       mag = 18'sd27246;
            4:       mag = 18'sd23170;
            5:       mag = 18'sd18205;
            6:       mag = 18'sd12540;
            7:       mag = 18'sd6393;
            default: mag = 18'sd0;
        endcase
        if (k == 0) mag = 18'sd23170;
        return neg ? -mag : mag;
    endfunction

    ctrl_t                  ctrl_q [Depth];
    ctrl_t                  ctrl_d;
    logic [2:0]             rowCnt_q, rowCnt_d;
    logic                   bankSel_q, bankSel_d;
    logic [2:0]             rowSel;

    logic signed [7:0]      rowIn_q [8];
    logic signed [31:0]     rowAcc [8];
    logic signed [15:0]     rowDct_d [8];
    logic signed [15:0]     bank_q [2][8][8];

    logic [2:0]             colRow;
    logic                   colBank;
    logic signed [17:0]     colCoef [8];
    logic signed [39:0]     colAcc [8];
    logic signed [7:0][15:0] colDct_d;
    logic signed [7:0][15:0] outData_q;

    // Row tagging: an in_sob forces row 0, and the bank flips after row 7 is accepted.
    always_comb begin
        ctrl_d       = '0;
        rowCnt_d     = rowCnt_q;
        bankSel_d    = bankSel_q;
        rowSel       = in_sob ? 3'd0 : rowCnt_q;
        ctrl_d.valid = in_valid;
        ctrl_d.sob   = in_valid & in_sob;
        ctrl_d.eob   = in_valid & in_eob;
        ctrl_d.sof   = in_valid & in_sof;
        ctrl_d.row   = rowSel;
        ctrl_d.bank  = bankSel_q;
        if (in_valid) begin
            rowCnt_d = rowSel + 3'd1;
            if (rowSel == 3'd7) bankSel_d = ~bankSel_q;
        end
    end

    // Control shift register, row counter, bank select and output register.
    // Reset clears all of them, so rows already in flight are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) ctrl_q[i] <= '0;
            rowCnt_q  <= '0;
            bankSel_q <= 1'b0;
            outData_q <= '0;
        end else begin
            ctrl_q[0] <= ctrl_d;
            for (int i = 1; i < Depth; i++) ctrl_q[i] <= ctrl_q[i-1];
            rowCnt_q  <= rowCnt_d;
            bankSel_q <= bankSel_d;
            if (ctrl_q[Depth-2].valid) outData_q <= colDct_d;
        end
    end

    // Datapath storage has no reset: the level-shifted input row and the transpose banks.
    // Subtracting 128 from an 8-bit pixel is the same as inverting its MSB.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int x = 0; x < 8; x++) rowIn_q[x] <= {~in_data[x][7], in_data[x][6:0]};
        end
        if (ctrl_q[0].valid) begin
            for (int v = 0; v < 8; v++) bank_q[ctrl_q[0].bank][ctrl_q[0].row][v] <= rowDct_d[v];
        end
    end

    // Row pass: 1D DCT of the registered row, rounded to 6 fractional bits.
    always_comb begin
        for (int v = 0; v < 8; v++) begin
            rowAcc[v] = '0;
            for (int x = 0; x < 8; x++) begin
                rowAcc[v] = rowAcc[v] + 32'(rowIn_q[x]) * 32'(dctCoef(v, x));
            end
            rowDct_d[v] = 16'((rowAcc[v] + 32'sd512) >>> 10);
        end
    end

    // Column pass: compute vertical frequency u = tagged row over all eight stored rows.
    // The result is rounded to 3 fractional bits with ties away from zero.
    always_comb begin
        colRow   = ctrl_q[Depth-2].row;
        colBank  = ctrl_q[Depth-2].bank;
        colDct_d = '0;
        for (int y = 0; y < 8; y++) colCoef[y] = '0;
        for (int k = 0; k < 8; k++) begin
            if (colRow == 3'(k)) begin
                for (int y = 0; y < 8; y++) colCoef[y] = dctCoef(k, y);
            end
        end
        for (int v = 0; v < 8; v++) begin
            colAcc[v] = '0;
            for (int y = 0; y < 8; y++) begin
                colAcc[v] = colAcc[v] + 40'(bank_q[colBank][y][v]) * 40'(colCoef[y]);
            end
            colDct_d[v] = 16'((colAcc[v] + (colAcc[v][39] ? 40'sd262143 : 40'sd262144)) >>> 19);
        end
    end

    assign out_valid = ctrl_q[Depth-1].valid;
    assign out_sob   = ctrl_q[Depth-1].sob;
    assign out_eob   = ctrl_q[Depth-1].eob;
    assign out_sof   = ctrl_q[Depth-1].sof;
    assign out_data  = outData_q;

endmodule

// File: tb/tb_dct_forward_transform.sv
// Self-checking bench for dct_forward_transform.
// A floating-point 2D DCT supplies the expected coefficients. A queue of recorded
// input cycles supplies the expected flags ten cycles later.
module tb_dct_forward_transform;

    localparam real Pi = 3.14159265358979323846;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic [7:0][7:0]         in_data = '0;
    logic                    in_sob = 1'b0;
    logic                    in_eob = 1'b0;
    logic                    in_sof = 1'b0;
    logic                    out_valid;
    logic signed [7:0][15:0] out_data;
    logic                    out_sob;
    logic                    out_eob;
    logic                    out_sof;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic valid;
        logic sob;
        logic eob;
        logic sof;
        int   blk;
        int   row;
    } rec_t;

    rec_t       pend [$];
    int         expCoef [16][8][8];
    int         litDc [16];
    bit         litOn [16];
    logic [7:0] pix [8][8];
    int         blkCount = 0;
    int         curBlk = 0;
    int         curRow = 0;

    dct_forward_transform dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sob    (in_sob),
        .in_eob    (in_eob),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sob   (out_sob),
        .out_eob   (out_eob),
        .out_sof   (out_sof)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Round to nearest, with ties away from zero.
    function automatic int roundAway(input real r);
        if (r >= 0.0) return int'($floor(r + 0.5));
        else return -int'($floor(-r + 0.5));
    endfunction

    // Ideal orthonormal 2D DCT-II of pix[][], scaled by 8 and rounded.
    function automatic void computeModel(input int id);
        real acc, cu, cv, s;
        for (int u = 0; u < 8; u++) begin
            for (int v = 0; v < 8; v++) begin
                acc = 0.0;
                for (int y = 0; y < 8; y++) begin
                    for (int x = 0; x < 8; x++) begin
                        s = real'(int'(pix[y][x])) - 128.0;
                        acc = acc + s * $cos((2.0 * x + 1.0) * v * Pi / 16.0)
                                      * $cos((2.0 * y + 1.0) * u * Pi / 16.0);
                    end
                end
                cu = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                cv = (v == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                expCoef[id][u][v] = roundAway(8.0 * 0.25 * cu * cv * acc);
            end
        end
    endfunction

    // Drive one block of nRows rows, then gap idle cycles.
    // mode 0 = constant val (DC must equal lit), 1 = random, 2 = checkerboard.
    task automatic applyStimulus(input int mode, input int val, input int lit,
                                 input bit sof, input int nRows, input int gap);
        int id;
        id = blkCount % 16;
        blkCount++;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                case (mode)
                    0:       pix[y][x] = 8'(val);
                    1:       pix[y][x] = 8'($urandom_range(0, 255));
                    default: pix[y][x] = (((x + y) % 2) == 0) ? 8'd255 : 8'd0;
                endcase
            end
        end
        computeModel(id);
        litOn[id] = (mode == 0);
        litDc[id] = lit;
        if (mode == 0) begin
            total++;
            if (expCoef[id][0][0] != lit) begin
                bad++;
                $display("[TB] FAIL model_dc blk=%0d got=%0d want=%0d", id, expCoef[id][0][0], lit);
            end
            total++;
            if (expCoef[id][2][5] != 0) begin
                bad++;
                $display("[TB] FAIL model_ac blk=%0d got=%0d want=0", id, expCoef[id][2][5]);
            end
        end
        for (int y = 0; y < nRows; y++) begin
            in_valid = 1'b1;
            for (int x = 0; x < 8; x++) in_data[x] = pix[y][x];
            in_sob = (y == 0);
            in_eob = (y == 7);
            in_sof = sof && (y == 0);
            curBlk = id;
            curRow = y;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_sob   = 1'b0;
        in_eob   = 1'b0;
        in_sof   = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare one output cycle against the record of the input cycle ten cycles earlier.
    task automatic checkOutput(input rec_t r);
        logic [3:0] want, got;
        int d, e;
        want = {r.valid, r.sob, r.eob, r.sof};
        got  = {out_valid, out_sob, out_eob, out_sof};
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL ctrl blk=%0d row=%0d got=%b want=%b", r.blk, r.row, got, want);
        end
        if (r.valid && out_valid) begin
            for (int v = 0; v < 8; v++) begin
                d = int'($signed(out_data[v]));
                e = expCoef[r.blk][r.row][v];
                total++;
                if ((d - e > 1) || (e - d > 1)) begin
                    bad++;
                    $display("[TB] FAIL coef blk=%0d u=%0d v=%0d got=%0d want=%0d", r.blk, r.row, v, d, e);
                end
            end
            if (litOn[r.blk] && r.row == 0) begin
                d = int'($signed(out_data[0]));
                total++;
                if (d != litDc[r.blk]) begin
                    bad++;
                    $display("[TB] FAIL dc_literal blk=%0d got=%0d want=%0d", r.blk, d, litDc[r.blk]);
                end
            end
        end
    endtask

    // Compare process: record inputs on every falling edge and check outputs with latency 10.
    // In reset every output must be zero. Until the history queue fills, out_valid must be zero.
    always @(negedge clk) begin
        rec_t r;
        if (!rst_n) begin
            pend.delete();
            total++;
            if ({out_valid, out_sob, out_eob, out_sof} !== 4'b0 || out_data !== '0) begin
                bad++;
                $display("[TB] FAIL reset_state got=%b data=%h want=0", {out_valid, out_sob, out_eob, out_sof}, out_data);
            end
        end else begin
            r.valid = in_valid;
            r.sob   = in_sob;
            r.eob   = in_eob;
            r.sof   = in_sof;
            r.blk   = curBlk;
            r.row   = curRow;
            pend.push_back(r);
            if (pend.size() > 10) begin
                checkOutput(pend.pop_front());
            end else begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL warmup_valid got=%b want=0", out_valid);
                end
            end
        end
    end

    // Bound the run so the bench always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence: directed constant blocks, back-to-back blocks, random traffic, mid-block reset.
    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(0, 128, 0,     1'b0, 8, 3);
        applyStimulus(0, 255, 8128,  1'b0, 8, 2);
        applyStimulus(0, 0,   -8192, 1'b1, 8, 5);
        applyStimulus(2, 0,   0,     1'b0, 8, 4);

        applyStimulus(0, 0,   -8192, 1'b0, 8, 0);
        applyStimulus(0, 128, 0,     1'b0, 8, 0);
        applyStimulus(0, 255, 8128,  1'b0, 8, 12);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 0, 0, ($urandom_range(0, 3) == 0), 8, $urandom_range(1, 36));
        end

        applyStimulus(1, 0, 0, 1'b1, 4, 0);
        #3;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 255, 8128, 1'b1, 8, 3);
        applyStimulus(1, 0, 0, 1'b0, 8, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
